// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall/redirect requests from the stages, stall/flush
// controls back to them, the redirect handshake toward the PC unit and the
// performance counters. master = core side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 8,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [NUM_STAGES-1:0]          i_stall_req;
    logic [NUM_STAGES-1:0]          i_redirect;
    logic [NUM_STAGES*PC_WIDTH-1:0] i_redirect_pc;
    logic                           i_pc_ack;
    logic [NUM_STAGES-1:0]          o_stall;
    logic [NUM_STAGES-1:0]          o_flush;
    logic                           o_pc_alter;
    logic [PC_WIDTH-1:0]            o_pc;
    logic [CNT_WIDTH-1:0]           o_stall_cnt;
    logic [CNT_WIDTH-1:0]           o_redirect_cnt;
    logic [CNT_WIDTH-1:0]           o_pend_cnt;

    modport master (
        output i_stall_req, i_redirect, i_redirect_pc, i_pc_ack,
        input  o_stall, o_flush, o_pc_alter, o_pc,
        input  o_stall_cnt, o_redirect_cnt, o_pend_cnt
    );

    modport slave (
        input  i_stall_req, i_redirect, i_redirect_pc, i_pc_ack,
        output o_stall, o_flush, o_pc_alter, o_pc,
        output o_stall_cnt, o_redirect_cnt, o_pend_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose: per-stage stall/flush generation and PC redirect handshake with perf counters.
// Latency: stall/flush/pc_alter/pc combinational (0 cycles); state and counters on the clock edge.
// Backpressure: a redirect not acked by the PC is held in PENDING until i_pc_ack; fetch flushed meanwhile.
//
// Ports: i_clk, i_rst (synchronous, active-high), bus (pipe_ctrl_if.slave)
// carrying stall/redirect requests in, stall/flush/redirect and counters out.
module pipe_ctrl #(
    parameter int NUM_STAGES = 8,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   pend_pc;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  redirect_cnt;
    logic [CNT_WIDTH-1:0]  pend_cnt;

    logic [NUM_STAGES-1:0] stall_above;
    logic [NUM_STAGES-1:0] redir_above;
    logic [NUM_STAGES-1:0] stall_mux;
    logic [NUM_STAGES-1:0] flush_mux;
    logic [PC_WIDTH-1:0]   win_pc;
    logic [PC_WIDTH-1:0]   pc_mux;
    logic                  alter_mux;
    logic                  any_redir;

    // stall_above[s]: some older stage k>s asks to stall.
    // redir_above[s]: some older stage k>s redirects, i.e. s is younger than
    // the winner and must be flushed.
    always_comb begin
        stall_above = '0;
        redir_above = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            stall_above[s] = |(bus.i_stall_req >> (s + 1));
            redir_above[s] = |(bus.i_redirect >> (s + 1));
        end
    end

    // Ascending scan: the last hit is the oldest requester, which wins.
    always_comb begin
        win_pc = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (bus.i_redirect[k]) begin
                win_pc = bus.i_redirect_pc[k*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign any_redir = |bus.i_redirect;

    always_comb begin
        flush_mux = redir_above;
        stall_mux = stall_above & ~redir_above;
        alter_mux = any_redir;
        pc_mux    = any_redir ? win_pc : '0;
        if (state == PENDING) begin
            // Keep fetch empty until the PC takes the redirect; a newer
            // redirect replaces the held target in the same cycle.
            flush_mux[0] = 1'b1;
            stall_mux[0] = 1'b0;
            alter_mux    = 1'b1;
            if (!any_redir) begin
                pc_mux = pend_pc;
            end
        end
        if (i_rst) begin
            flush_mux = '1;
            stall_mux = '0;
            alter_mux = 1'b0;
            pc_mux    = '0;
        end
    end

    assign bus.o_stall        = stall_mux;
    assign bus.o_flush        = flush_mux;
    assign bus.o_pc_alter     = alter_mux;
    assign bus.o_pc           = pc_mux;
    assign bus.o_stall_cnt    = i_rst ? '0 : stall_cnt;
    assign bus.o_redirect_cnt = i_rst ? '0 : redirect_cnt;
    assign bus.o_pend_cnt     = i_rst ? '0 : pend_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            pend_pc      <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
            pend_cnt     <= '0;
        end else begin
            if (state == IDLE) begin
                if (any_redir && !bus.i_pc_ack) begin
                    state   <= PENDING;
                    pend_pc <= win_pc;
                end
            end else begin
                if (bus.i_pc_ack) begin
                    state <= IDLE;
                end else if (any_redir) begin
                    pend_pc <= win_pc;
                end
            end

            // Counters saturate at all-ones.
            if (stall_mux[0] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (any_redir && (redirect_cnt != '1)) begin
                redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
            end
            if ((state == PENDING) && (pend_cnt != '1)) begin
                pend_cnt <= pend_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order core: turns per-stage stall requests and per-stage redirect requests into per-stage stall and flush controls, and gives the program counter a redirect with a handshake. It replaces the fixed point-to-point stall/flush wiring in the core top level, so any number of stages can raise a redirect. The oldest request wins. A redirect the PC cannot take at once is held until the PC acknowledges it. It also keeps saturating performance counters.

## Interface
- NUM_STAGES, 8, number of stages; stage 0 = fetch (youngest), stage NUM_STAGES-1 = writeback (oldest); must be at least 2
- PC_WIDTH, 32, width of a redirect PC
- CNT_WIDTH, 32, width of each performance counter
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_stall_req  in  NUM_STAGES  bit k: stage k cannot accept new input this cycle
- i_redirect  in  NUM_STAGES  bit k: stage k requests a redirect; single-cycle pulse
- i_redirect_pc  in  NUM_STAGES*PC_WIDTH  target for stage k at [k*PC_WIDTH +: PC_WIDTH]
- i_pc_ack  in  1  PC unit accepts o_pc this cycle
- o_stall  out  NUM_STAGES  bit s: stage s holds its contents
- o_flush  out  NUM_STAGES  bit s: stage s invalidates its contents
- o_pc_alter  out  1  redirect valid toward the PC
- o_pc  out  PC_WIDTH  redirect target
- o_stall_cnt  out  CNT_WIDTH  cycles with o_stall[0]=1
- o_redirect_cnt  out  CNT_WIDTH  redirects accepted
- o_pend_cnt  out  CNT_WIDTH  cycles spent in PENDING

## Operation
- Registers:
  - state: IDLE or PENDING
  - pend_pc: PC_WIDTH bits
  - the three counters
- Winner w: the highest index k with i_redirect[k]=1. A redirect is "accepted" in any cycle where i_redirect is non-zero.
- Stall, combinational:
  - o_stall[s] = OR of i_stall_req[k] for all k>s
  - o_stall[NUM_STAGES-1] = 0
- On an accepted redirect:
  - o_flush[s]=1 for every s<w
  - o_stall[s] forced to 0 for every s<w (flush beats stall)
  - stages at or above w are untouched
- Redirect in IDLE:
  - o_pc_alter=1, o_pc=target of w, in the same cycle
  - i_pc_ack=1: stay in IDLE
  - i_pc_ack=0: load pend_pc with target of w and go to PENDING
- PENDING:
  - o_pc_alter=1, o_flush[0]=1, o_stall[0]=0, so no wrong-path fetch enters
  - o_pc = pend_pc, unless a new redirect arrives this cycle; then o_pc = the new winner's target, the new winner's flush mask applies, and pend_pc takes the new target (a newer redirect always comes from an older instruction)
  - i_pc_ack=1: go to IDLE
- No redirect in IDLE: o_flush=0, o_pc_alter=0, o_pc=0.
- Counters:
  - each increments by 1 under its condition
  - each saturates at all-ones and never wraps
  - o_pend_cnt counts every cycle where state is PENDING at the start of the cycle

## Timing
- Stall, flush, o_pc_alter and o_pc are combinational from the inputs and state: zero-cycle latency.
- State, pend_pc and the counters update on the rising edge of i_clk.
- While i_rst=1:
  - outputs are forced: o_flush all ones, o_stall=0, o_pc_alter=0, o_pc=0
  - counters read 0
  - the next edge clears state to IDLE, pend_pc to 0 and all counters
- Reset asserted while in PENDING drops the pending redirect with no acknowledge.
- Handshake: the redirect completes on the edge where o_pc_alter=1 and i_pc_ack=1. o_pc stays stable from the first cycle until that edge, unless an accepted redirect replaces it.
- Redirect plus i_pc_ack in the same IDLE cycle: zero extra cycles, o_redirect_cnt +1, o_pend_cnt unchanged.
- Simultaneous redirects: only the winner's target is used; the winner's mask already covers every lower requester.
- A stall request from stage w in the redirect cycle still stalls stages at or above... no: stages above w are unaffected by it; stages below w are flushed, not stalled.

## Test plan
- NUM_STAGES=8, i_stall_req=8'b0001_0000, no redirect -> o_stall=8'b0000_1111, o_flush=0, o_stall_cnt +1 per cycle.
- i_redirect=8'b0010_0100, stage-5 target 0x8000_0100, stage-2 target 0x8000_0200, i_pc_ack=1 -> o_flush=8'b0001_1111, o_pc=0x8000_0100, o_pc_alter=1 for one cycle, state stays IDLE, o_redirect_cnt=1.
- i_redirect[7] with target 0x1000 and i_pc_ack=0 for 3 cycles, then 1:
  - cycle 0: o_flush=8'b0111_1111
  - cycles 1-3: o_flush=8'b0000_0001, o_pc=0x1000
  - returns to IDLE after ack; o_pend_cnt=3
- In PENDING with target 0x1000, i_redirect[6] with target 0x2000, no ack -> o_pc=0x2000 in that cycle and the next, o_flush=8'b0011_1111 in that cycle, o_redirect_cnt +1.
- In PENDING, assert i_rst for 1 cycle -> o_flush=8'hFF during reset; the next cycle is IDLE, o_pc_alter=0, all counters 0.
- CNT_WIDTH=4, hold i_stall_req[1]=1 for 20 cycles -> o_stall_cnt reaches 4'hF and stays there.
